// File: rtl/input_io_filt_pkg.sv
// Shared types and constants for the input IO cell and its glitch filter.
package input_io_filt_pkg;

  localparam int unsigned CNT_W        = 8;
  localparam int unsigned FILT_CNT_MIN = 1;
  localparam int unsigned FILT_CNT_MAX = 255;

  localparam string MODE_BUFF = "in_buff";
  localparam string MODE_REG  = "in_reg";
  localparam string MODE_FILT = "in_filt";

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    STABLE  = 2'd1,
    QUALIFY = 2'd2
  } filt_state_e;

  // Fabric-side payload: level, edge pulses, level-qualified flag
  typedef struct packed {
    logic lvl;
    logic rise;
    logic fall;
    logic vld;
  } a2f_t;

endpackage

// File: rtl/input_io_filt_if.sv
// Pad/fabric signal bundle for the input IO cell.
//  IP        pad input          IQE       capture enable
//  A2F       level to fabric    A2F_RISE  0->1 pulse
//  A2F_FALL  1->0 pulse         A2F_VLD   level qualified
interface input_io_filt_if;
  logic IP;
  logic IQE;
  logic A2F;
  logic A2F_RISE;
  logic A2F_FALL;
  logic A2F_VLD;

  modport master (output IP, IQE, input A2F, A2F_RISE, A2F_FALL, A2F_VLD);
  modport slave  (input IP, IQE, output A2F, A2F_RISE, A2F_FALL, A2F_VLD);
endinterface

// File: rtl/input_io_filt_glitch.sv
// Two-flop synchroniser plus counting glitch filter with edge pulses.
//  clk, rst_n  clock / async active-low reset
//  ip          raw pad level
//  iqe         enable; 0 freezes the filter (synchroniser keeps running)
//  a2f         registered level, rise/fall pulses, valid flag
module io_glitch_filter
  import input_io_filt_pkg::*;
#(
  parameter int unsigned FILT_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ip,
  input  logic iqe,
  output a2f_t a2f
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(FILT_CNT);

  filt_state_e      state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx, cnt_inc;
  logic             s1_q, s2_q;
  logic             cand_q, cand_nx;
  logic             settle_done;
  logic             upd;
  a2f_t             out_q, out_nx;

  // State, counter, synchroniser and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
      cand_q  <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      cand_q  <= cand_nx;
      s1_q    <= ip;
      s2_q    <= s1_q;
      out_q   <= out_nx;
    end
  end

  // Next state / counter; settle_done and upd flag a level acceptance
  always_comb begin
    state_nx    = state_q;
    cnt_nx      = cnt_q;
    cand_nx     = cand_q;
    cnt_inc     = cnt_q + CNT_ONE;
    settle_done = 1'b0;
    upd         = 1'b0;
    if (iqe) begin
      case (state_q)
        SETTLE: begin
          cand_nx = s2_q;
          // A new candidate restarts the run at one sample
          cnt_inc = (s2_q != cand_q) ? CNT_ONE : cnt_q + CNT_ONE;
          if (cnt_inc == CNT_TGT) begin
            settle_done = 1'b1;
            cnt_nx      = '0;
            state_nx    = STABLE;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        STABLE: begin
          if (s2_q != out_q.lvl) begin
            if (FILT_CNT == 1) begin
              upd = 1'b1;
            end else begin
              cnt_nx   = CNT_ONE;
              state_nx = QUALIFY;
            end
          end else begin
            cnt_nx = '0;
          end
        end
        QUALIFY: begin
          if (s2_q == out_q.lvl) begin
            cnt_nx   = '0;
            state_nx = STABLE;
          end else if (cnt_inc == CNT_TGT) begin
            upd      = 1'b1;
            cnt_nx   = '0;
            state_nx = STABLE;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        default: begin
          cnt_nx   = '0;
          state_nx = SETTLE;
        end
      endcase
    end
  end

  // Output update: settling sets the level silently, qualified changes pulse
  always_comb begin
    out_nx      = out_q;
    out_nx.rise = 1'b0;
    out_nx.fall = 1'b0;
    if (settle_done) begin
      out_nx.lvl = s2_q;
      out_nx.vld = 1'b1;
    end
    if (upd) begin
      out_nx.lvl  = s2_q;
      out_nx.rise = s2_q;
      out_nx.fall = ~s2_q;
    end
  end

  assign a2f = out_q;

endmodule

// File: rtl/input_io_filt.sv
// Input-direction IO cell: pad -> fabric, as buffer, register or filter.
//  IQC   clock               QRT  async active-low reset
//  io    slave side of input_io_filt_if (IP, IQE in; A2F, A2F_RISE,
//        A2F_FALL, A2F_VLD out)
(* whitebox *)
(* MODES = "in_buff; in_reg; in_filt" *)
module input_io_filt
  import input_io_filt_pkg::*;
#(
  parameter string       MODE     = "in_filt",
  parameter int unsigned FILT_CNT = 4
) (
  input  logic            IQC,
  input  logic            QRT,
  input_io_filt_if.slave  io
);

  // Pad node standing in for the VPR_IPAD primitive; must survive synthesis
  (* keep *) logic ipad;
  assign ipad = io.IP;

  if (FILT_CNT < FILT_CNT_MIN || FILT_CNT > FILT_CNT_MAX) begin : g_bad_cnt
    $error("input_io_filt: FILT_CNT %0d outside legal range", FILT_CNT);
  end

  if (MODE == MODE_BUFF) begin : g_buff
    logic unused_buff;
    assign unused_buff = ^{IQC, QRT, io.IQE};
    assign io.A2F      = ipad;
    assign io.A2F_RISE = 1'b0;
    assign io.A2F_FALL = 1'b0;
    assign io.A2F_VLD  = 1'b1;
  end else if (MODE == MODE_REG) begin : g_reg
    a2f_t q;
    // Capture on enabled edges; valid from the first edge after reset
    always_ff @(posedge IQC or negedge QRT) begin
      if (!QRT) begin
        q <= '0;
      end else begin
        q.vld  <= 1'b1;
        q.rise <= 1'b0;
        q.fall <= 1'b0;
        if (io.IQE) begin
          q.lvl  <= ipad;
          q.rise <= ipad & ~q.lvl;
          q.fall <= ~ipad & q.lvl;
        end
      end
    end
    assign io.A2F      = q.lvl;
    assign io.A2F_RISE = q.rise;
    assign io.A2F_FALL = q.fall;
    assign io.A2F_VLD  = q.vld;
  end else if (MODE == MODE_FILT) begin : g_filt
    a2f_t q;
    io_glitch_filter #(
      .FILT_CNT (FILT_CNT)
    ) u_filt (
      .clk   (IQC),
      .rst_n (QRT),
      .ip    (ipad),
      .iqe   (io.IQE),
      .a2f   (q)
    );
    assign io.A2F      = q.lvl;
    assign io.A2F_RISE = q.rise;
    assign io.A2F_FALL = q.fall;
    assign io.A2F_VLD  = q.vld;
  end else begin : g_bad_mode
    $error("input_io_filt: unknown MODE %s", MODE);
  end

endmodule

// File: tb/tb_input_io_filt.sv
// Directed bench for input_io_filt in filter (FILT_CNT 4 and 1), register and buffer modes.
module tb_input_io_filt;

  logic IQC;
  logic QRT;
  int   errors = 0;
  int   checks = 0;

  input_io_filt_if f4 ();
  input_io_filt_if f1 ();
  input_io_filt_if rg ();
  input_io_filt_if bf ();

  input_io_filt #(.MODE("in_filt"), .FILT_CNT(4)) u_f4 (.IQC(IQC), .QRT(QRT), .io(f4.slave));
  input_io_filt #(.MODE("in_filt"), .FILT_CNT(1)) u_f1 (.IQC(IQC), .QRT(QRT), .io(f1.slave));
  input_io_filt #(.MODE("in_reg"),  .FILT_CNT(4)) u_rg (.IQC(IQC), .QRT(QRT), .io(rg.slave));
  input_io_filt #(.MODE("in_buff"), .FILT_CNT(4)) u_bf (.IQC(IQC), .QRT(QRT), .io(bf.slave));

  initial IQC = 1'b0;
  always #5 IQC = ~IQC;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge IQC);
  endtask

  initial begin
    QRT = 1'b1;
    f4.IP = 1'b0; f4.IQE = 1'b0;
    f1.IP = 1'b0; f1.IQE = 1'b0;
    rg.IP = 1'b0; rg.IQE = 1'b0;
    bf.IP = 1'b0; bf.IQE = 1'b0;
    #2 QRT = 1'b0;
    #1;
    chk("rst_f4_a2f",  f4.A2F,      1'b0);
    chk("rst_f4_rise", f4.A2F_RISE, 1'b0);
    chk("rst_f4_fall", f4.A2F_FALL, 1'b0);
    chk("rst_f4_vld",  f4.A2F_VLD,  1'b0);
    chk("rst_rg_vld",  rg.A2F_VLD,  1'b0);
    chk("rst_rg_a2f",  rg.A2F,      1'b0);

    // Test 1: IP=1 from reset release, settle after 6 edges without a pulse
    @(negedge IQC);
    f4.IP = 1'b1; f4.IQE = 1'b1;
    f1.IP = 1'b1; f1.IQE = 1'b1;
    QRT = 1'b1;
    tick(3);
    chk("t1_f1_a2f",  f1.A2F,      1'b1);
    chk("t1_f1_rise", f1.A2F_RISE, 1'b1);
    chk("t1_f1_vld",  f1.A2F_VLD,  1'b1);
    tick(1);
    chk("t1_f1_rise_end", f1.A2F_RISE, 1'b0);
    tick(1);
    chk("t1_f4_a2f_c5", f4.A2F,     1'b0);
    chk("t1_f4_vld_c5", f4.A2F_VLD, 1'b0);
    tick(1);
    chk("t1_f4_a2f_c6",  f4.A2F,      1'b1);
    chk("t1_f4_vld_c6",  f4.A2F_VLD,  1'b1);
    chk("t1_f4_rise_c6", f4.A2F_RISE, 1'b0);

    // Qualified fall to reach a settled A2F=0
    f4.IP = 1'b0;
    tick(5);
    chk("fall_a2f_c5",  f4.A2F,      1'b1);
    chk("fall_fall_c5", f4.A2F_FALL, 1'b0);
    tick(1);
    chk("fall_a2f_c6",  f4.A2F,      1'b0);
    chk("fall_fall_c6", f4.A2F_FALL, 1'b1);
    chk("fall_rise_c6", f4.A2F_RISE, 1'b0);
    tick(1);
    chk("fall_fall_end", f4.A2F_FALL, 1'b0);

    // Test 2: 3-cycle glitch is rejected
    f4.IP = 1'b1;
    tick(3);
    f4.IP = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("t2_glitch_a2f",  f4.A2F,      1'b0);
      chk("t2_glitch_rise", f4.A2F_RISE, 1'b0);
    end

    // Test 3: held step passes after exactly 6 edges with one RISE pulse
    f4.IP = 1'b1;
    tick(5);
    chk("t3_a2f_c5", f4.A2F, 1'b0);
    tick(1);
    chk("t3_a2f_c6",  f4.A2F,      1'b1);
    chk("t3_rise_c6", f4.A2F_RISE, 1'b1);
    chk("t3_fall_c6", f4.A2F_FALL, 1'b0);
    tick(1);
    chk("t3_rise_end", f4.A2F_RISE, 1'b0);
    chk("t3_a2f_hold", f4.A2F,      1'b1);

    // Test 4: IQE low for 10 cycles mid-QUALIFY (cnt=2), then resume
    f4.IP = 1'b0;
    tick(4);
    f4.IQE = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t4_hold_a2f",  f4.A2F,      1'b1);
      chk("t4_hold_fall", f4.A2F_FALL, 1'b0);
    end
    f4.IQE = 1'b1;
    tick(1);
    chk("t4_resume_a2f_c1", f4.A2F, 1'b1);
    tick(1);
    chk("t4_resume_a2f_c2",  f4.A2F,      1'b0);
    chk("t4_resume_fall_c2", f4.A2F_FALL, 1'b1);

    // Test 5: async reset mid-QUALIFY, then full settle delay again
    f4.IP = 1'b1;
    tick(7);
    chk("t5_pre_a2f", f4.A2F, 1'b1);
    f4.IP = 1'b0;
    tick(4);
    chk("t5_qual_a2f", f4.A2F, 1'b1);
    #2 QRT = 1'b0;
    #1;
    chk("t5_rst_a2f",  f4.A2F,      1'b0);
    chk("t5_rst_vld",  f4.A2F_VLD,  1'b0);
    chk("t5_rst_rise", f4.A2F_RISE, 1'b0);
    chk("t5_rst_fall", f4.A2F_FALL, 1'b0);
    @(negedge IQC);
    f4.IP = 1'b1;
    QRT = 1'b1;
    tick(1);
    chk("t6_rg_vld_first", rg.A2F_VLD, 1'b1);
    chk("t6_rg_a2f_first", rg.A2F,     1'b0);
    tick(4);
    chk("t5_a2f_c5", f4.A2F,     1'b0);
    chk("t5_vld_c5", f4.A2F_VLD, 1'b0);
    tick(1);
    chk("t5_a2f_c6",  f4.A2F,      1'b1);
    chk("t5_vld_c6",  f4.A2F_VLD,  1'b1);
    chk("t5_rise_c6", f4.A2F_RISE, 1'b0);

    // Test 6: register mode captures only on enabled edges
    rg.IP = 1'b1; rg.IQE = 1'b0;
    tick(1);
    chk("t6_rg_noen", rg.A2F, 1'b0);
    rg.IQE = 1'b1;
    #1;
    chk("t6_rg_not_comb", rg.A2F, 1'b0);
    tick(1);
    chk("t6_rg_cap1",  rg.A2F,      1'b1);
    chk("t6_rg_rise1", rg.A2F_RISE, 1'b1);
    rg.IP = 1'b0;
    tick(1);
    chk("t6_rg_cap0",  rg.A2F,      1'b0);
    chk("t6_rg_fall0", rg.A2F_FALL, 1'b1);
    chk("t6_rg_rise0", rg.A2F_RISE, 1'b0);
    rg.IP = 1'b1; rg.IQE = 1'b0;
    tick(1);
    chk("t6_rg_hold",      rg.A2F,      1'b0);
    chk("t6_rg_hold_fall", rg.A2F_FALL, 1'b0);
    rg.IQE = 1'b1;
    tick(1);
    chk("t6_rg_cap1b",  rg.A2F,      1'b1);
    chk("t6_rg_rise1b", rg.A2F_RISE, 1'b1);

    // Buffer mode: zero-delay pass-through
    bf.IP = 1'b1;
    #1;
    chk("t6_bf_hi", bf.A2F, 1'b1);
    bf.IP = 1'b0;
    #1;
    chk("t6_bf_lo",   bf.A2F,      1'b0);
    chk("t6_bf_vld",  bf.A2F_VLD,  1'b1);
    chk("t6_bf_rise", bf.A2F_RISE, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
